// File: rtl/n_clic_timer.sv
// CSR-mapped prescaled timer: counter vs. compare, sticky pending bit drives a level
// interrupt request into n_clic. CSR op encoding shared through n_clic_timer_pkg.
package n_clic_timer_pkg;
  typedef enum logic [2:0] {
    CSR_RW  = 3'b001,
    CSR_RS  = 3'b010,
    CSR_RC  = 3'b011,
    CSR_RWI = 3'b101,
    CSR_RSI = 3'b110,
    CSR_RCI = 3'b111
  } csr_op_t;
endpackage

module n_clic_timer
  import n_clic_timer_pkg::*;
#(
  parameter logic [11:0] BaseAddr   = 12'h400,
  parameter int unsigned PrescWidth = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          csr_enable,
  input  logic [11:0]   csr_addr,
  input  csr_op_t       csr_op,
  input  logic [4:0]    rs1_zimm,
  input  logic [31:0]   rs1_data,
  output logic [31:0]   csr_out,
  output logic          interrupt_out
);
  localparam int unsigned DataW = 32;
  localparam int unsigned DivLsb = 8;

  logic                  en_q, en_d;
  logic                  periodic_q, periodic_d;
  logic [PrescWidth-1:0] div_q, div_d;
  logic                  pend_q, pend_d;
  logic [DataW-1:0]      cmp_q, cmp_d;
  logic [DataW-1:0]      cnt_q, cnt_d;
  logic [PrescWidth-1:0] psc_q, psc_d;

  logic             hit_ctrl, hit_cmp, hit_cnt;
  logic [DataW-1:0] ctrl_val, old_val, src, wr_val;
  logic             wr_en, tick, hit_match, pend_clr;

  // Address decode, read mux and write-value formation
  always_comb begin
    hit_ctrl = csr_enable && (csr_addr == BaseAddr);
    hit_cmp  = csr_enable && (csr_addr == BaseAddr + 12'd1);
    hit_cnt  = csr_enable && (csr_addr == BaseAddr + 12'd2);

    ctrl_val                      = '0;
    ctrl_val[0]                   = en_q;
    ctrl_val[1]                   = periodic_q;
    ctrl_val[DivLsb +: PrescWidth] = div_q;
    ctrl_val[31]                  = pend_q;

    old_val = '0;
    if (hit_ctrl)     old_val = ctrl_val;
    else if (hit_cmp) old_val = cmp_q;
    else if (hit_cnt) old_val = cnt_q;

    src    = csr_op[2] ? DataW'(rs1_zimm) : rs1_data;
    wr_en  = 1'b0;
    wr_val = old_val;
    case (csr_op)
      CSR_RW, CSR_RWI: begin
        wr_en  = 1'b1;
        wr_val = src;
      end
      CSR_RS, CSR_RSI: begin
        wr_en  = (rs1_zimm != 5'd0);
        wr_val = old_val | src;
      end
      CSR_RC, CSR_RCI: begin
        wr_en  = (rs1_zimm != 5'd0);
        wr_val = old_val & ~src;
      end
      default: begin
        wr_en  = 1'b0;
        wr_val = old_val;
      end
    endcase
  end

  assign csr_out       = old_val;
  assign interrupt_out = pend_q;

  // Tick effects first, then CSR write overrides on the register it targets
  always_comb begin
    tick      = en_q && (psc_q == div_q);
    hit_match = tick && (cnt_q == cmp_q);
    pend_clr  = ~wr_val[31] & (pend_q | src[31]);

    en_d       = en_q;
    periodic_d = periodic_q;
    div_d      = div_q;
    pend_d     = pend_q | hit_match;
    cmp_d      = cmp_q;
    cnt_d      = cnt_q;
    psc_d      = psc_q;

    if (en_q) psc_d = tick ? '0 : psc_q + PrescWidth'(1);
    if (tick) cnt_d = hit_match ? '0 : cnt_q + 32'd1;
    if (hit_match && !periodic_q) en_d = 1'b0;

    if (wr_en && hit_ctrl) begin
      en_d       = wr_val[0];
      periodic_d = wr_val[1];
      div_d      = wr_val[DivLsb +: PrescWidth];
      pend_d     = wr_val[31] | (hit_match & ~pend_clr);
      psc_d      = '0;
    end
    if (wr_en && hit_cmp) cmp_d = wr_val;
    if (wr_en && hit_cnt) begin
      cnt_d = wr_val;
      psc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      div_q      <= '0;
      pend_q     <= 1'b0;
      cmp_q      <= 32'hFFFF_FFFF;
      cnt_q      <= '0;
      psc_q      <= '0;
    end else begin
      en_q       <= en_d;
      periodic_q <= periodic_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      cmp_q      <= cmp_d;
      cnt_q      <= cnt_d;
      psc_q      <= psc_d;
    end
  end
endmodule

// File: tb/tb_n_clic_timer.sv
// Directed bench for n_clic_timer: CSR accesses driven on negedge, results checked
// with immediate assertions against hand-computed values.
module tb_n_clic_timer;
  import n_clic_timer_pkg::*;

  localparam logic [11:0] ACtrl = 12'h400;
  localparam logic [11:0] ACmp  = 12'h401;
  localparam logic [11:0] ACnt  = 12'h402;

  logic        clk;
  logic        reset;
  logic        csr_enable;
  logic [11:0] csr_addr;
  csr_op_t     csr_op;
  logic [4:0]  rs1_zimm;
  logic [31:0] rs1_data;
  logic [31:0] csr_out;
  logic        interrupt_out;

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [31:0] v;

  n_clic_timer #(.BaseAddr(12'h400), .PrescWidth(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .csr_enable    (csr_enable),
    .csr_addr      (csr_addr),
    .csr_op        (csr_op),
    .rs1_zimm      (rs1_zimm),
    .rs1_data      (rs1_data),
    .csr_out       (csr_out),
    .interrupt_out (interrupt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One-cycle CSR instruction; entered and left on a falling edge
  task automatic csr(input csr_op_t op, input logic [11:0] addr, input logic [4:0] zimm,
                     input logic [31:0] data, output logic [31:0] rd);
    csr_enable = 1'b1;
    csr_op     = op;
    csr_addr   = addr;
    rs1_zimm   = zimm;
    rs1_data   = data;
    #1 rd = csr_out;
    @(negedge clk);
    csr_enable = 1'b0;
    csr_addr   = 12'h000;
    csr_op     = CSR_RW;
    rs1_zimm   = 5'd0;
    rs1_data   = 32'd0;
  endtask

  task automatic rd(input logic [11:0] addr, output logic [31:0] val);
    csr(CSR_RS, addr, 5'd0, 32'd0, val);
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    csr(CSR_RW, addr, 5'd1, data, dummy);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset      = 1'b0;
    csr_enable = 1'b0;
    csr_addr   = 12'h000;
    csr_op     = CSR_RW;
    rs1_zimm   = 5'd0;
    rs1_data   = 32'd0;
    idle(3);
    reset = 1'b1;

    // Reset values
    check("rst_irq", 32'(interrupt_out), 32'd0);
    rd(ACtrl, v); check("rst_ctrl", v, 32'h0000_0000);
    rd(ACmp,  v); check("rst_cmp",  v, 32'hFFFF_FFFF);
    rd(ACnt,  v); check("rst_cnt",  v, 32'h0000_0000);

    // Periodic, div=0, cmp=3: hit every 4 ticks
    wr(ACmp, 32'd3);
    wr(ACtrl, 32'h0000_0003);
    idle(3); check("per_irq_e3", 32'(interrupt_out), 32'd0);
    idle(1); check("per_irq_e4", 32'(interrupt_out), 32'd1);
    rd(ACnt, v); check("per_cnt_after_hit", v, 32'd0);
    csr(CSR_RC, ACtrl, 5'd7, 32'h8000_0000, v);
    check("per_rc_old", v, 32'h8000_0003);
    check("per_irq_cleared", 32'(interrupt_out), 32'd0);
    idle(1); check("per_irq_e7", 32'(interrupt_out), 32'd0);
    idle(1); check("per_irq_e8", 32'(interrupt_out), 32'd1);
    wr(ACtrl, 32'h0);
    check("per_off_irq", 32'(interrupt_out), 32'd0);

    // Prescaler div=2, one-shot, cmp=1
    wr(ACnt, 32'd0);
    wr(ACmp, 32'd1);
    wr(ACtrl, 32'h0000_0201);
    idle(5); check("os_irq_e5", 32'(interrupt_out), 32'd0);
    idle(1); check("os_irq_e6", 32'(interrupt_out), 32'd1);
    rd(ACtrl, v); check("os_ctrl", v, 32'h8000_0200);
    idle(5);
    rd(ACnt, v); check("os_cnt_hold", v, 32'd0);

    // Op semantics: zimm=0 set is read-only and keeps the prescaler phase
    wr(ACtrl, 32'h0);
    wr(ACmp, 32'hFFFF_FFFF);
    wr(ACnt, 32'd0);
    wr(ACtrl, 32'h0000_0501);
    idle(2);
    csr(CSR_RSI, ACtrl, 5'd0, 32'hFFFF_FFFF, v); check("rsi0_old", v, 32'h0000_0501);
    idle(2);
    rd(ACnt, v); check("rsi0_cnt_pre", v, 32'd0);
    rd(ACnt, v); check("rsi0_cnt_tick", v, 32'd1);
    rd(ACtrl, v); check("rsi0_ctrl", v, 32'h0000_0501);
    csr(CSR_RWI, ACnt, 5'd5, 32'hFFFF_FFFF, v); check("rwi_old", v, 32'd1);
    rd(ACnt, v); check("rwi_cnt", v, 32'd5);
    csr(CSR_RW, 12'h300, 5'd1, 32'h1234_5678, v); check("nohit_out", v, 32'd0);
    rd(ACmp, v); check("nohit_cmp", v, 32'hFFFF_FFFF);

    // Collision: CNT write on the cycle of a hit tick (div=1, cmp=1)
    wr(ACtrl, 32'h0);
    wr(ACnt, 32'd0);
    wr(ACmp, 32'd1);
    wr(ACtrl, 32'h0000_0103);
    idle(3);
    csr(CSR_RW, ACnt, 5'd1, 32'd100, v); check("col_old", v, 32'd1);
    check("col_irq", 32'(interrupt_out), 32'd1);
    rd(ACnt, v); check("col_cnt", v, 32'd100);
    rd(ACtrl, v); check("col_ctrl", v, 32'h8000_0103);

    // Wrap-around through zero up to compare
    wr(ACtrl, 32'h0);
    wr(ACnt, 32'hFFFF_FFFE);
    wr(ACmp, 32'd1);
    wr(ACtrl, 32'h0000_0003);
    idle(1);
    rd(ACnt, v); check("wrap_ffff", v, 32'hFFFF_FFFF);
    rd(ACnt, v); check("wrap_0", v, 32'd0);
    check("wrap_irq_pre", 32'(interrupt_out), 32'd0);
    rd(ACnt, v); check("wrap_1", v, 32'd1);
    check("wrap_irq", 32'(interrupt_out), 32'd1);

    // Asynchronous reset mid-count
    reset = 1'b0;
    #1 check("arst_irq", 32'(interrupt_out), 32'd0);
    idle(2);
    reset = 1'b1;
    rd(ACtrl, v); check("arst_ctrl", v, 32'h0000_0000);
    rd(ACmp,  v); check("arst_cmp",  v, 32'hFFFF_FFFF);
    rd(ACnt,  v); check("arst_cnt",  v, 32'h0000_0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
